// File: rtl/hit_check_grouped_pkg.sv
// Shared sprite-entry field layout, default geometry, FSM encodings and a 9-bit |a-b| helper.
package hit_check_grouped_pkg;

  localparam int unsigned SPR_X_LSB     = 0;
  localparam int unsigned SPR_Y_LSB     = 8;
  localparam int unsigned SPR_VALID_BIT = 31;
  localparam int unsigned SPR_GRP_LSB   = 24;

  localparam int unsigned SPR_W_DEF     = 16;
  localparam int unsigned SPR_H_DEF     = 16;
  localparam int unsigned GROUP_NUM_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Unsigned 8-bit coordinates, no wrap: the difference is taken in 9 bits.
  function automatic logic [8:0] abs_diff9(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? (~d + 9'd1) : d;
  endfunction

endpackage

// File: rtl/hit_check_grouped_aabb_cmp.sv
// Combinational pair test: both valid, groups collide (mask treated as symmetric), boxes overlap.
module hit_aabb_cmp
  import hit_check_grouped_pkg::*;
#(
  parameter int unsigned GROUP_NUM = GROUP_NUM_DEF,
  parameter int unsigned SPR_W     = SPR_W_DEF,
  parameter int unsigned SPR_H     = SPR_H_DEF
) (
  input  logic [31:0]                      entry_a_i,
  input  logic [31:0]                      entry_b_i,
  input  logic [GROUP_NUM*GROUP_NUM-1:0]   mask_i,
  output logic                             hit_o
);

  localparam int unsigned GW = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;

  logic [GW-1:0]   grp_a;
  logic [GW-1:0]   grp_b;
  logic [2*GW-1:0] bit_ab;
  logic [2*GW-1:0] bit_ba;
  logic [8:0]      dx;
  logic [8:0]      dy;
  logic            grp_ok;
  logic            unused_bits;

  assign grp_a  = entry_a_i[SPR_GRP_LSB +: GW];
  assign grp_b  = entry_b_i[SPR_GRP_LSB +: GW];
  // GROUP_NUM is a power of two, so a*G+b is just the concatenation {a,b}.
  assign bit_ab = {grp_a, grp_b};
  assign bit_ba = {grp_b, grp_a};
  assign grp_ok = mask_i[bit_ab] | mask_i[bit_ba];

  assign dx = abs_diff9(entry_a_i[SPR_X_LSB +: 8], entry_b_i[SPR_X_LSB +: 8]);
  assign dy = abs_diff9(entry_a_i[SPR_Y_LSB +: 8], entry_b_i[SPR_Y_LSB +: 8]);

  assign hit_o = entry_a_i[SPR_VALID_BIT] & entry_b_i[SPR_VALID_BIT] & grp_ok &
                 ({23'd0, dx} < SPR_W) & ({23'd0, dy} < SPR_H);

  assign unused_bits = ^{entry_a_i[30:SPR_GRP_LSB+GW], entry_a_i[23:16],
                         entry_b_i[30:SPR_GRP_LSB+GW], entry_b_i[23:16]};

endmodule

// File: rtl/hit_check_grouped.sv
// Per-frame sprite collision: load all entries from sprite RAM, test every pair once,
// then publish the hit bitmask with a done pulse. Latency 1+(N+1)+N(N-1)/2 cycles; starts while busy are dropped.
module hit_check_grouped
  import hit_check_grouped_pkg::*;
#(
  parameter int unsigned SPRITE_NUM_MAX = 64,
  parameter int unsigned SPR_W          = SPR_W_DEF,
  parameter int unsigned SPR_H          = SPR_H_DEF,
  parameter int unsigned GROUP_NUM      = GROUP_NUM_DEF,
  parameter int unsigned IDX_W          = $clog2(SPRITE_NUM_MAX)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            hitCheckStart,
  input  logic [GROUP_NUM*GROUP_NUM-1:0]  groupMask,
  output logic [IDX_W-1:0]                hitCheck_spriteViewRamIndex,
  input  logic [31:0]                     spriteViewRamDataO_hitCheck,
  output logic [SPRITE_NUM_MAX-1:0]       allSpriteHit,
  output logic                            hitCheckBusy,
  output logic                            hitCheckDone
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPRITE_NUM_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(SPRITE_NUM_MAX - 2);
  localparam logic [IDX_W:0]   CNT_END  = (IDX_W+1)'(SPRITE_NUM_MAX);

  logic [1:0]                     state_q,  state_d;
  logic [IDX_W-1:0]               idx_q,    idx_d;
  logic [IDX_W:0]                 cnt_q,    cnt_d;
  logic [IDX_W-1:0]               i_q,      i_d;
  logic [IDX_W-1:0]               j_q,      j_d;
  logic [GROUP_NUM*GROUP_NUM-1:0] mask_q,   mask_d;
  logic [SPRITE_NUM_MAX-1:0]      work_q,   work_d;
  logic [SPRITE_NUM_MAX-1:0]      hit_q,    hit_d;
  logic                           done_q,   done_d;
  logic [31:0]                    spr_buf_q [SPRITE_NUM_MAX];
  logic [IDX_W-1:0]               wr_idx;
  logic                           pair_hit;

  hit_aabb_cmp #(
    .GROUP_NUM (GROUP_NUM),
    .SPR_W     (SPR_W),
    .SPR_H     (SPR_H)
  ) u_cmp (
    .entry_a_i (spr_buf_q[i_q]),
    .entry_b_i (spr_buf_q[j_q]),
    .mask_i    (mask_q),
    .hit_o     (pair_hit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    mask_d  = mask_q;
    work_d  = work_q;
    hit_d   = hit_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hitCheckStart) begin
          mask_d  = groupMask;
          work_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // RAM data lags the index by one cycle, so the final cycle only drains.
        if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
        cnt_d = cnt_q + (IDX_W+1)'(1);
        if (cnt_q == CNT_END) begin
          i_d     = '0;
          j_d     = IDX_W'(1);
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (pair_hit) begin
          work_d[i_q] = 1'b1;
          work_d[j_q] = 1'b1;
        end
        if (j_q == IDX_LAST) begin
          if (i_q == IDX_PEN) begin
            state_d = ST_DONE;
          end else begin
            i_d = i_q + IDX_W'(1);
            j_d = i_q + IDX_W'(2);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      default: begin
        hit_d   = work_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      mask_q  <= '0;
      work_q  <= '0;
      hit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      mask_q  <= mask_d;
      work_q  <= work_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  assign wr_idx = IDX_W'(cnt_q - (IDX_W+1)'(1));

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && cnt_q != '0) spr_buf_q[wr_idx] <= spriteViewRamDataO_hitCheck;
  end

  assign hitCheck_spriteViewRamIndex = idx_q;
  assign allSpriteHit                = hit_q;
  assign hitCheckBusy                = (state_q != ST_IDLE);
  assign hitCheckDone                = done_q;

endmodule

// File: tb/tb_hit_check_grouped.sv
// Directed bench: N=4 instance driven from a vector table plus hand sequences, and an N=64 regression.
module tb_hit_check_grouped;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        start4 = 1'b0;
  logic [15:0] gm4 = '0;
  logic [1:0]  idx4;
  logic [31:0] dat4 = '0;
  logic [3:0]  hit4;
  logic        busy4, done4;
  logic [31:0] mem4 [4];

  logic        start64 = 1'b0;
  logic [15:0] gm64 = '0;
  logic [5:0]  idx64;
  logic [31:0] dat64 = '0;
  logic [63:0] hit64;
  logic        busy64, done64;
  logic [31:0] mem64 [64];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hit_check_grouped #(.SPRITE_NUM_MAX(4)) dut4 (
    .clk(clk), .rstn(rstn), .hitCheckStart(start4), .groupMask(gm4),
    .hitCheck_spriteViewRamIndex(idx4), .spriteViewRamDataO_hitCheck(dat4),
    .allSpriteHit(hit4), .hitCheckBusy(busy4), .hitCheckDone(done4)
  );

  hit_check_grouped #(.SPRITE_NUM_MAX(64)) dut64 (
    .clk(clk), .rstn(rstn), .hitCheckStart(start64), .groupMask(gm64),
    .hitCheck_spriteViewRamIndex(idx64), .spriteViewRamDataO_hitCheck(dat64),
    .allSpriteHit(hit64), .hitCheckBusy(busy64), .hitCheckDone(done64)
  );

  // Synchronous RAM: data follows the index by one clock.
  always @(posedge clk) begin
    dat4  <= mem4[idx4];
    dat64 <= mem64[idx64];
  end

  typedef struct {
    logic [31:0] s0, s1, s2, s3;
    logic [15:0] gm;
    logic [3:0]  exp;
  } vec_t;

  vec_t vt [12];

  function automatic logic [31:0] mk(input bit v, input int g, input int x, input int y);
    return {v, 4'b0000, 3'(g), 8'h00, 8'(y), 8'(x)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    mem4[0] = a; mem4[1] = b; mem4[2] = c; mem4[3] = d;
  endtask

  task automatic run4(input logic [15:0] gm, output logic [3:0] hit, output int lat,
                      output bit busy_ok, output bit hold_ok);
    logic [3:0] prev;
    prev = hit4; lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    @(negedge clk); start4 = 1'b1; gm4 = gm;
    @(posedge clk); #1; start4 = 1'b0;
    if (!busy4) busy_ok = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done4) begin lat = k; break; end
      if (!busy4) busy_ok = 1'b0;
      if (hit4 !== prev) hold_ok = 1'b0;
    end
    if (busy4) busy_ok = 1'b0;
    hit = hit4;
  endtask

  initial begin
    logic [3:0]  h;
    int          lat;
    bit          bok, hok;
    int          ndone;
    logic [63:0] exp64;
    localparam logic [31:0] INV = 32'h0;

    vt[0]  = '{mk(1,0,10,10),  mk(1,1,20,15),   INV, INV, 16'h0002, 4'b0011};
    vt[1]  = '{mk(1,0,10,10),  mk(1,1,26,10),   INV, INV, 16'h0002, 4'b0000};
    vt[2]  = '{mk(1,0,10,10),  mk(1,1,25,10),   INV, INV, 16'h0002, 4'b0011};
    vt[3]  = '{mk(1,0,10,10),  mk(1,0,12,12),   INV, INV, 16'h0002, 4'b0000};
    vt[4]  = '{mk(1,0,10,10),  mk(1,0,12,12),   INV, INV, 16'h0001, 4'b0011};
    vt[5]  = '{mk(1,1,10,10),  mk(1,0,12,12),   INV, INV, 16'h0002, 4'b0011};
    vt[6]  = '{mk(1,0,250,10), mk(1,1,2,10),    INV, INV, 16'h0002, 4'b0000};
    vt[7]  = '{mk(1,0,10,10),  mk(1,1,10,26),   INV, INV, 16'h0002, 4'b0000};
    vt[8]  = '{mk(1,0,10,10),  mk(1,1,25,25),   INV, INV, 16'h0002, 4'b0011};
    vt[9]  = '{mk(1,0,0,0),    mk(1,1,100,100), mk(1,1,5,5), mk(1,0,105,105), 16'h0002, 4'b1111};
    vt[10] = '{mk(1,0,0,0),    mk(1,1,100,100), mk(1,1,5,5), mk(0,0,105,105), 16'h0002, 4'b0101};
    vt[11] = '{mk(0,0,10,10),  mk(1,1,12,12),   INV, INV, 16'h0002, 4'b0000};

    load4(INV, INV, INV, INV);
    for (int k = 0; k < 64; k++) mem64[k] = INV;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit",  {60'd0, hit4}, 64'd0);
    chk("rst_busy", {63'd0, busy4}, 64'd0);
    chk("rst_done", {63'd0, done4}, 64'd0);
    chk("rst_idx",  {62'd0, idx4}, 64'd0);
    chk("rst_hit64", hit64, 64'd0);
    @(negedge clk); rstn = 1'b1;

    for (int v = 0; v < 12; v++) begin
      load4(vt[v].s0, vt[v].s1, vt[v].s2, vt[v].s3);
      run4(vt[v].gm, h, lat, bok, hok);
      chk($sformatf("vec%0d_hit", v), {60'd0, h}, {60'd0, vt[v].exp});
      chk($sformatf("vec%0d_lat", v), 64'(lat), 64'd12);
      chk($sformatf("vec%0d_busy", v), {63'd0, bok}, 64'd1);
      chk($sformatf("vec%0d_hold", v), {63'd0, hok}, 64'd1);
    end

    // Starts during LOAD and on the DONE edge are dropped; one cycle later is accepted.
    load4(vt[0].s0, vt[0].s1, vt[0].s2, vt[0].s3);
    ndone = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      start4 = (k == 0 || k == 2 || k == 5 || k == 12 || k == 13);
      gm4 = 16'h0002;
      @(posedge clk); #1;
      if (k <= 4) chk($sformatf("idx_seq%0d", k), {62'd0, idx4}, (k < 4) ? 64'(k) : 64'd3);
      if (done4) begin
        ndone++;
        if (ndone == 1) chk("ign_done_at", 64'(k), 64'd12);
        else            chk("acc_done_at", 64'(k), 64'd25);
      end
      if (k == 12) chk("ign_busy_after_done", {63'd0, busy4}, 64'd0);
      if (k == 13) chk("acc_busy", {63'd0, busy4}, 64'd1);
    end
    start4 = 1'b0;
    chk("ign_ndone", 64'(ndone), 64'd2);
    chk("ign_hit", {60'd0, hit4}, 64'h3);

    // Reset in the middle of the pair sweep.
    @(negedge clk); start4 = 1'b1; gm4 = 16'h0002;
    @(posedge clk); #1; start4 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_hit",  {60'd0, hit4}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy4}, 64'd0);
    chk("mid_rst_done", {63'd0, done4}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("mid_rst_nodone", 64'(ndone), 64'd0);
    run4(16'h0002, h, lat, bok, hok);
    chk("post_rst_hit", {60'd0, h}, 64'h3);
    chk("post_rst_lat", 64'(lat), 64'd12);

    // N=64: diagonal chain with x wrapping past 255, groups k%4.
    gm64 = 16'h0122;
    for (int k = 0; k < 64; k++) mem64[k] = mk(1, k % 4, (k * 10) % 256, (k * 3) % 256);
    exp64 = '0;
    for (int a = 0; a < 64; a++) begin
      for (int b = a + 1; b < 64; b++) begin
        int xa, xb, ya, yb, dx, dy, ga, gb;
        xa = (a * 10) % 256; xb = (b * 10) % 256;
        ya = (a * 3) % 256;  yb = (b * 3) % 256;
        dx = (xa > xb) ? xa - xb : xb - xa;
        dy = (ya > yb) ? ya - yb : yb - ya;
        ga = a % 4; gb = b % 4;
        if (dx < 16 && dy < 16 && (gm64[ga*4+gb] || gm64[gb*4+ga])) begin
          exp64[a] = 1'b1;
          exp64[b] = 1'b1;
        end
      end
    end
    @(negedge clk); start64 = 1'b1;
    @(posedge clk); #1; start64 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (done64) begin lat = k; break; end
    end
    chk("n64_lat", 64'(lat), 64'd2082);
    chk("n64_hit", hit64, exp64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
